// File: rtl/jesd204_tx_link_seq.sv
// Transmit-side JESD204B link sequencer: WAIT -> CGS -> ILAS -> DATA.
// Drives the lane octet-source select strobes and ILAS multiframe markers.
// Ports:
//   clk, cgs_reset (async, active-high)
//   phy_ready     : TX PHY ready
//   sync_n        : SYNC~ from receiver (active-low, synchronised)
//   lmfc_edge     : one-cycle LMFC boundary pulse
//   state         : 0=WAIT 1=CGS 2=ILAS 3=DATA
//   send_cgs/send_ilas/send_data : one-hot octet source select (none in WAIT)
//   ilas_mf_cnt   : current ILAS multiframe index
//   ilas_mf_start : first cycle of each ILAS multiframe
//   ilas_cfg_mf   : ILAS multiframe carrying the link configuration
//   sync_loss     : pulse on fallback to CGS from ILAS/DATA
module jesd204_tx_link_seq #(
  parameter int unsigned NUM_ILAS_MF      = 4,
  parameter int unsigned SYNC_LOSS_CYCLES = 4
) (
  input  logic       clk,
  input  logic       cgs_reset,
  input  logic       phy_ready,
  input  logic       sync_n,
  input  logic       lmfc_edge,
  output logic [1:0] state,
  output logic       send_cgs,
  output logic       send_ilas,
  output logic       send_data,
  output logic [7:0] ilas_mf_cnt,
  output logic       ilas_mf_start,
  output logic       ilas_cfg_mf,
  output logic       sync_loss
);

  localparam int unsigned CNT_W    = 8;
  localparam logic [CNT_W-1:0] LOSS_MAX = CNT_W'(SYNC_LOSS_CYCLES);
  localparam logic [CNT_W-1:0] LAST_MF  = CNT_W'(NUM_ILAS_MF - 1);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_CGS  = 2'd1,
    ST_ILAS = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] loss_q, loss_d, loss_inc;
  logic [CNT_W-1:0] cnt_d;
  logic             start_d, loss_pulse_d, cfg_d;
  logic             send_cgs_d, send_ilas_d, send_data_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge cgs_reset) begin
    if (cgs_reset) begin
      state_q       <= ST_WAIT;
      loss_q        <= '0;
      ilas_mf_cnt   <= '0;
      ilas_mf_start <= 1'b0;
      ilas_cfg_mf   <= 1'b0;
      sync_loss     <= 1'b0;
      send_cgs      <= 1'b0;
      send_ilas     <= 1'b0;
      send_data     <= 1'b0;
    end else begin
      state_q       <= state_d;
      loss_q        <= loss_d;
      ilas_mf_cnt   <= cnt_d;
      ilas_mf_start <= start_d;
      ilas_cfg_mf   <= cfg_d;
      sync_loss     <= loss_pulse_d;
      send_cgs      <= send_cgs_d;
      send_ilas     <= send_ilas_d;
      send_data     <= send_data_d;
    end
  end

  assign state = 2'(state_q);

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = ilas_mf_cnt;
    loss_d       = '0;
    start_d      = 1'b0;
    loss_pulse_d = 1'b0;
    loss_inc     = '0;

    // Count of consecutive sync_n-low cycles including the current one
    if ((state_q == ST_ILAS || state_q == ST_DATA) && !sync_n) begin
      loss_inc = (loss_q >= LOSS_MAX) ? LOSS_MAX : loss_q + CNT_W'(1);
    end

    if (!phy_ready) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_WAIT: state_d = ST_CGS;
        ST_CGS: begin
          if (sync_n && lmfc_edge) begin
            state_d = ST_ILAS;
            cnt_d   = '0;
            start_d = 1'b1;
          end
        end
        ST_ILAS, ST_DATA: begin
          // Sync loss beats ILAS completion on the same edge
          if (loss_inc == LOSS_MAX) begin
            state_d      = ST_CGS;
            cnt_d        = '0;
            loss_pulse_d = 1'b1;
          end else begin
            loss_d = loss_inc;
            if (state_q == ST_ILAS && lmfc_edge) begin
              if (ilas_mf_cnt == LAST_MF) begin
                state_d = ST_DATA;
              end else begin
                cnt_d   = ilas_mf_cnt + CNT_W'(1);
                start_d = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_WAIT;
      endcase
    end

    send_cgs_d  = (state_d == ST_CGS);
    send_ilas_d = (state_d == ST_ILAS);
    send_data_d = (state_d == ST_DATA);
    cfg_d       = send_ilas_d && (cnt_d == CNT_W'(1));
  end

endmodule

// File: tb/tb_jesd204_tx_link_seq.sv
// Directed bench for jesd204_tx_link_seq (NUM_ILAS_MF=4, SYNC_LOSS_CYCLES=4, LMFC period 16).
module tb_jesd204_tx_link_seq;

  logic       clk, cgs_reset, phy_ready, sync_n, lmfc_edge;
  logic [1:0] state;
  logic       send_cgs, send_ilas, send_data;
  logic [7:0] ilas_mf_cnt;
  logic       ilas_mf_start, ilas_cfg_mf, sync_loss;

  int passed = 0;
  int total  = 0;

  jesd204_tx_link_seq #(.NUM_ILAS_MF(4), .SYNC_LOSS_CYCLES(4)) dut (
    .clk(clk), .cgs_reset(cgs_reset), .phy_ready(phy_ready), .sync_n(sync_n),
    .lmfc_edge(lmfc_edge), .state(state), .send_cgs(send_cgs), .send_ilas(send_ilas),
    .send_data(send_data), .ilas_mf_cnt(ilas_mf_cnt), .ilas_mf_start(ilas_mf_start),
    .ilas_cfg_mf(ilas_cfg_mf), .sync_loss(sync_loss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected packed vector {state, send_cgs, send_ilas, send_data, start, cfg, sync_loss}
  function automatic logic [7:0] ev(input logic [1:0] st, input logic start, input logic cfg,
                                    input logic loss);
    return {st, st == 2'd1, st == 2'd2, st == 2'd3, start, cfg, loss};
  endfunction

  task automatic chk(input string tag, input logic [7:0] exp_vec, input logic [7:0] exp_cnt);
    logic [7:0] obs;
    obs = {state, send_cgs, send_ilas, send_data, ilas_mf_start, ilas_cfg_mf, sync_loss};
    total++;
    assert (obs === exp_vec && ilas_mf_cnt === exp_cnt) passed++;
    else $error("FAIL %s: outputs=%b cnt=%0d, expected outputs=%b cnt=%0d",
                tag, obs, ilas_mf_cnt, exp_vec, exp_cnt);
  endtask

  // Apply lmfc_edge for one active edge, then sample 1 time unit after it
  task automatic tick(input logic lm);
    lmfc_edge = lm;
    @(posedge clk);
    #1;
    lmfc_edge = 1'b0;
  endtask

  // Walk one ILAS multiframe m (already in its start cycle) and take its closing LMFC edge
  task automatic ilas_mf(input int m);
    logic cfg;
    cfg = (m == 1);
    for (int i = 0; i < 15; i++) begin
      tick(1'b0);
      chk("ilas_body", ev(2'd2, 1'b0, cfg, 1'b0), 8'(m));
    end
    tick(1'b1);
    if (m < 3) chk("ilas_next_mf", ev(2'd2, 1'b1, (m + 1) == 1, 1'b0), 8'(m + 1));
    else       chk("ilas_to_data", ev(2'd3, 1'b0, 1'b0, 1'b0), 8'd3);
  endtask

  initial begin
    cgs_reset = 1'b1;
    phy_ready = 1'b0;
    sync_n    = 1'b0;
    lmfc_edge = 1'b0;
    #12;
    chk("reset_values", ev(2'd0, 1'b0, 1'b0, 1'b0), 8'd0);
    cgs_reset = 1'b0;

    // Cycles 1..5 in WAIT; phy_ready rises for cycle 5's edge -> CGS at cycle 6
    for (int c = 1; c <= 4; c++) begin
      tick(1'b0);
      chk("wait_hold", ev(2'd0, 1'b0, 1'b0, 1'b0), 8'd0);
    end
    phy_ready = 1'b1;
    tick(1'b0);
    chk("wait_to_cgs", ev(2'd1, 1'b0, 1'b0, 1'b0), 8'd0);

    // LMFC edge with sync_n low is ignored in CGS
    tick(1'b1);
    chk("cgs_sync_low_edge", ev(2'd1, 1'b0, 1'b0, 1'b0), 8'd0);

    // sync_n high 3 cycles before the edge: stay CGS until the edge
    sync_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      chk("cgs_sync_high_no_edge", ev(2'd1, 1'b0, 1'b0, 1'b0), 8'd0);
    end
    tick(1'b1);
    chk("cgs_to_ilas", ev(2'd2, 1'b1, 1'b0, 1'b0), 8'd0);
    for (int m = 0; m < 4; m++) ilas_mf(m);

    // DATA holds, DATA-side LMFC edges have no effect
    tick(1'b1);
    chk("data_hold", ev(2'd3, 1'b0, 1'b0, 1'b0), 8'd3);

    // 3-cycle sync_n glitch: no effect
    sync_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      chk("data_glitch", ev(2'd3, 1'b0, 1'b0, 1'b0), 8'd3);
    end
    sync_n = 1'b1;
    tick(1'b0);
    chk("data_after_glitch", ev(2'd3, 1'b0, 1'b0, 1'b0), 8'd3);

    // 4 low cycles: CGS with one-cycle sync_loss
    sync_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      chk("data_low_count", ev(2'd3, 1'b0, 1'b0, 1'b0), 8'd3);
    end
    tick(1'b0);
    chk("data_sync_loss", ev(2'd1, 1'b0, 1'b0, 1'b1), 8'd0);
    tick(1'b0);
    chk("sync_loss_one_cycle", ev(2'd1, 1'b0, 1'b0, 1'b0), 8'd0);
    tick(1'b1);
    chk("recgs_edge_sync_low", ev(2'd1, 1'b0, 1'b0, 1'b0), 8'd0);
    sync_n = 1'b1;
    tick(1'b0);
    chk("recgs_sync_high", ev(2'd1, 1'b0, 1'b0, 1'b0), 8'd0);
    tick(1'b1);
    chk("recgs_to_ilas", ev(2'd2, 1'b1, 1'b0, 1'b0), 8'd0);

    // 4th low cycle coincides with final LMFC edge: CGS wins
    for (int m = 0; m < 3; m++) ilas_mf(m);
    for (int c = 0; c < 12; c++) begin
      tick(1'b0);
      chk("ilas_last_mf", ev(2'd2, 1'b0, 1'b0, 1'b0), 8'd3);
    end
    sync_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1'b0);
      chk("ilas_low_count", ev(2'd2, 1'b0, 1'b0, 1'b0), 8'd3);
    end
    tick(1'b1);
    chk("loss_beats_data", ev(2'd1, 1'b0, 1'b0, 1'b1), 8'd0);

    // Back to DATA, then drop phy_ready: WAIT without sync_loss
    sync_n = 1'b1;
    tick(1'b1);
    chk("third_ilas", ev(2'd2, 1'b1, 1'b0, 1'b0), 8'd0);
    for (int m = 0; m < 4; m++) ilas_mf(m);
    phy_ready = 1'b0;
    tick(1'b0);
    chk("phy_drop_wait", ev(2'd0, 1'b0, 1'b0, 1'b0), 8'd0);
    tick(1'b0);
    chk("phy_low_hold", ev(2'd0, 1'b0, 1'b0, 1'b0), 8'd0);
    phy_ready = 1'b1;
    tick(1'b0);
    chk("phy_back_cgs", ev(2'd1, 1'b0, 1'b0, 1'b0), 8'd0);
    tick(1'b1);
    chk("fourth_ilas", ev(2'd2, 1'b1, 1'b0, 1'b0), 8'd0);
    tick(1'b0);
    chk("ilas_before_reset", ev(2'd2, 1'b0, 1'b0, 1'b0), 8'd0);

    // Async reset mid-cycle in ILAS: clears with no clock edge
    #3;
    cgs_reset = 1'b1;
    #1;
    chk("async_reset", ev(2'd0, 1'b0, 1'b0, 1'b0), 8'd0);
    #1;
    cgs_reset = 1'b0;
    tick(1'b0);
    chk("after_reset_cgs", ev(2'd1, 1'b0, 1'b0, 1'b0), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jesd204_tx_link_seq.md
Name: jesd204_tx_link_seq

Overview:
Transmit-side link sequencer for a JESD204B lane group; the counterpart of the receive controller that drives PHY character alignment and CGS. It sequences WAIT -> CGS -> ILAS -> DATA from the receiver's SYNC~ request and the local LMFC. It also drives the octet-source select strobes for the TX lane muxes. It sits between the PHY reset controller and the per-lane K28.5 / ILAS / user-data muxes.

Parameters:
NUM_ILAS_MF, 4, number of ILAS multiframes transmitted (1..255).
SYNC_LOSS_CYCLES, 4, consecutive sync_n-low cycles in ILAS/DATA that force a return to CGS (1..255).

Ports:
clk  input  1  link clock.
cgs_reset  input  1  asynchronous, active-high reset.
phy_ready  input  1  TX PHY ready, synchronous to clk.
sync_n  input  1  SYNC~ from receiver, active-low, already synchronised to clk.
lmfc_edge  input  1  one-cycle pulse on each LMFC boundary.
state  output  2  0=WAIT, 1=CGS, 2=ILAS, 3=DATA.
send_cgs  output  1  lanes emit K28.5.
send_ilas  output  1  lanes emit ILAS octets.
send_data  output  1  lanes emit user data.
ilas_mf_cnt  output  8  index of current ILAS multiframe.
ilas_mf_start  output  1  first cycle of each ILAS multiframe.
ilas_cfg_mf  output  1  current multiframe carries link config (ilas_mf_cnt==1).
sync_loss  output  1  one-cycle pulse on re-entry to CGS from ILAS/DATA.

Behaviour:
- Moore outputs; all registered, all clear on cgs_reset assertion with no clock needed.
- Reset values: state=WAIT, all send_* 0, ilas_mf_cnt=0, ilas_mf_start=0, ilas_cfg_mf=0, sync_loss=0.
- Output decode:
  - WAIT: all send_* 0.
  - CGS: send_cgs=1.
  - ILAS: send_ilas=1.
  - DATA: send_data=1.
  - Exactly one send_* is high outside WAIT.
- Transitions, evaluated at posedge, first match wins:
  1. phy_ready==0 in any state -> WAIT. sync_loss is not pulsed. Loss counter and ilas_mf_cnt clear.
  2. WAIT & phy_ready -> CGS next cycle.
  3. CGS & sync_n==1 & lmfc_edge -> ILAS next cycle; ilas_mf_cnt=0, ilas_mf_start=1 in first ILAS cycle. sync_n high without lmfc_edge: stay in CGS.
  4. ILAS or DATA & loss counter reaches SYNC_LOSS_CYCLES -> CGS next cycle; sync_loss=1 in that first CGS cycle only.
  5. ILAS & lmfc_edge & ilas_mf_cnt==NUM_ILAS_MF-1 -> DATA next cycle; ilas_mf_cnt holds.
  6. ILAS & lmfc_edge otherwise -> ilas_mf_cnt+1, ilas_mf_start=1 next cycle.
- Rule 4 has priority over rule 5 when both trigger in the same cycle: CGS wins.
- Loss counter, 8-bit, internal:
  - Increments each cycle sync_n==0 while in ILAS/DATA; saturates at SYNC_LOSS_CYCLES.
  - Clears on sync_n==1 or any other state.
  - A low glitch shorter than SYNC_LOSS_CYCLES has no effect.
- ilas_mf_start is high for exactly one cycle per ILAS multiframe, NUM_ILAS_MF pulses in total per ILAS pass.
- ilas_cfg_mf = send_ilas & (ilas_mf_cnt==1).
- Latency: CGS->ILAS and last ILAS multiframe->DATA are each one cycle after the qualifying lmfc_edge.
- sync_n low in CGS is normal and ignored. A new ILAS starts only on an LMFC edge with sync_n high.
- cgs_reset mid-ILAS/DATA: immediate WAIT with no sync_loss pulse. After release, needs phy_ready again.

Test Plan:
- Reset release, phy_ready=1 at cycle 5 -> state WAIT through cycle 5, CGS at cycle 6, send_cgs=1, others 0.
- In CGS, sync_n rises 3 cycles before an lmfc_edge, LMFC period 16 -> stay CGS until the edge, then ILAS next cycle.
  - ilas_mf_start pulses 4 times, 16 cycles apart.
  - ilas_mf_cnt steps 0,1,2,3; ilas_cfg_mf high only during cnt==1.
  - DATA one cycle after the 4th edge.
- In DATA, sync_n low for 3 cycles then high -> remain DATA, sync_loss stays 0.
- In DATA, sync_n low for 4 cycles -> CGS on the following cycle with sync_loss=1 for one cycle. The next ILAS waits for sync_n high plus lmfc_edge.
- sync_n reaches its 4th low cycle in ILAS on the same cycle as the final lmfc_edge -> CGS, not DATA; sync_loss=1.
- In DATA, phy_ready drops -> WAIT next cycle with sync_loss=0. Separately, async cgs_reset pulse mid-cycle in ILAS -> outputs clear immediately, state=WAIT.
